// File: rtl/button_pkg.sv
// Shared types and default constants for the button event decoder.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int LONG_PRESS_DEF    = 100;
  localparam int REPEAT_PERIOD_DEF = 20;
  localparam int CNT_W_DEF         = 7;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_if.sv
// Debounced button level in, decoded command events out.
interface button_event_if;
  logic btn;
  logic short_press;
  logic long_press;
  logic repeat_tick;
  logic held;

  modport master (
    output btn,
    input  short_press,
    input  long_press,
    input  repeat_tick,
    input  held
  );

  modport slave (
    input  btn,
    output short_press,
    output long_press,
    output repeat_tick,
    output held
  );
endinterface

// File: rtl/button_event.sv
// Press classifier: short press, long press, and (with BUTTON_EVENT_AUTO_REPEAT_EN
// defined) periodic repeat ticks while the button stays held.
module button_event
  import button_pkg::*;
#(
  parameter int LONG_PRESS    = LONG_PRESS_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  button_event_if.slave bus
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS - 1);
  localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(max2(LONG_PRESS, REPEAT_PERIOD));

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             short_reg, short_next;
  logic             long_reg, long_next;
  logic             tick_reg, tick_next;
  logic             held_reg, held_next;

  // Saturating increment: unreachable for legal parameters, but never wraps.
  assign cnt_inc = (cnt_reg == CNT_TOP) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      short_reg <= 1'b0;
      long_reg  <= 1'b0;
      tick_reg  <= 1'b0;
      held_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      short_reg <= short_next;
      long_reg  <= long_next;
      tick_reg  <= tick_next;
      held_reg  <= held_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    short_next = 1'b0;
    long_next  = 1'b0;
    tick_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.btn) begin
          state_next = PRESS;
          cnt_next   = CNT_W'(1);
        end
      end

      PRESS: begin
        if (!bus.btn) begin
          short_next = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == LONG_LAST) begin
          long_next  = 1'b1;
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      HOLD: begin
        if (!bus.btn) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
          if (cnt_reg == CNT_W'(REPEAT_PERIOD - 1)) begin
            tick_next = 1'b1;
            cnt_next  = '0;
          end else begin
            cnt_next = cnt_inc;
          end
`else
          cnt_next = '0;
`endif
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    held_next = (state_next == HOLD);
  end

  assign bus.short_press = short_reg;
  assign bus.long_press  = long_reg;
  assign bus.repeat_tick = tick_reg;
  assign bus.held        = held_reg;

endmodule

// File: tb/tb_button_event.sv
// Randomized and directed self-check of button_event against a run-length model.
module tb_button_event;

  localparam int LONG = 100;
  localparam int RP   = 20;

  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;
  int   run;
  bit   auto_rep;

  button_event_if bus_if();

  button_event #(
    .LONG_PRESS   (LONG),
    .REPEAT_PERIOD(RP),
    .CNT_W        (7)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: counts consecutive high samples; events follow from the run length.
  // Vector layout: {short_press, long_press, repeat_tick, held}.
  task automatic model_step(input logic b, output logic [3:0] e);
    e = 4'b0000;
    if (b) begin
      run++;
      if (run >= LONG) e[0] = 1'b1;
      if (run == LONG) e[2] = 1'b1;
      else if (auto_rep && run > LONG && ((run - LONG) % RP) == 0) e[1] = 1'b1;
    end else begin
      if (run > 0 && run < LONG) e[3] = 1'b1;
      run = 0;
    end
  endtask

  function automatic logic [3:0] observe();
    return {bus_if.short_press, bus_if.long_press, bus_if.repeat_tick, bus_if.held};
  endfunction

  // Drive one sample, let it be taken, and return expected and observed outputs.
  task automatic apply(input logic b, output logic [3:0] e, output logic [3:0] o);
    bus_if.btn = b;
    @(posedge clock);
    #1;
    model_step(b, e);
    o = observe();
  endtask

  task automatic test_reset();
    logic [3:0] e, o;
    int n_long;
    n_long = 0;
    reset_n    = 1'b0;
    bus_if.btn = 1'b1;
    run        = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      vectors++;
      if (observe() !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_hold cycle=%0d got=%b want=0000", i, observe());
      end
    end
    reset_n = 1'b1;
    for (int i = 1; i <= LONG; i++) begin
      apply(1'b1, e, o);
      n_long += o[2];
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_release sample=%0d got=%b want=%b", i, o, e);
      end
    end
    vectors++;
    if (n_long !== 1) begin
      miscompares++;
      $display("FAIL reset_long_count got=%0d want=1", n_long);
    end
    apply(1'b0, e, o);
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL reset_release_low got=%b want=%b", o, e);
    end
    $display("test_reset: press of %0d samples after reset release", LONG);
  endtask

  task automatic test_short_press();
    logic [3:0] e, o;
    int n_short, n_long, n_held;
    n_short = 0; n_long = 0; n_held = 0;
    for (int i = 0; i <= 30; i++) begin
      apply((i < 30) ? 1'b1 : 1'b0, e, o);
      n_short += o[3]; n_long += o[2]; n_held += o[0];
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL short sample=%0d got=%b want=%b", i, o, e);
      end
    end
    vectors++;
    if (n_short !== 1 || n_long !== 0 || n_held !== 0) begin
      miscompares++;
      $display("FAIL short_counts got=%0d/%0d/%0d want=1/0/0", n_short, n_long, n_held);
    end
    apply(1'b0, e, o);
    $display("test_short_press: 30 high samples");
  endtask

  task automatic test_long_press();
    logic [3:0] e, o;
    int n_short, n_long, n_tick, n_held;
    n_short = 0; n_long = 0; n_tick = 0; n_held = 0;
    for (int i = 0; i <= LONG; i++) begin
      apply((i < LONG) ? 1'b1 : 1'b0, e, o);
      n_short += o[3]; n_long += o[2]; n_tick += o[1]; n_held += o[0];
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL long sample=%0d got=%b want=%b", i, o, e);
      end
    end
    vectors++;
    if (n_short !== 0 || n_long !== 1 || n_tick !== 0 || n_held !== 1) begin
      miscompares++;
      $display("FAIL long_counts got=%0d/%0d/%0d/%0d want=0/1/0/1", n_short, n_long, n_tick, n_held);
    end
    $display("test_long_press: %0d high samples", LONG);
  endtask

  task automatic test_auto_repeat();
    logic [3:0] e, o;
    int n_tick, want;
    n_tick = 0;
    want = auto_rep ? 3 : 0;
    for (int i = 0; i <= 160; i++) begin
      apply((i < 160) ? 1'b1 : 1'b0, e, o);
      n_tick += o[1];
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL repeat sample=%0d got=%b want=%b", i, o, e);
      end
    end
    vectors++;
    if (n_tick !== want) begin
      miscompares++;
      $display("FAIL repeat_count got=%0d want=%0d", n_tick, want);
    end
    $display("test_auto_repeat: 160 high samples, %0d ticks expected", want);
  endtask

  task automatic test_boundary();
    logic [3:0] e, o;
    int n_short, n_long;
    n_short = 0; n_long = 0;
    for (int i = 0; i <= LONG - 1; i++) begin
      apply((i < LONG - 1) ? 1'b1 : 1'b0, e, o);
      n_short += o[3]; n_long += o[2];
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL boundary sample=%0d got=%b want=%b", i, o, e);
      end
    end
    vectors++;
    if (n_short !== 1 || n_long !== 0) begin
      miscompares++;
      $display("FAIL boundary_counts got=%0d/%0d want=1/0", n_short, n_long);
    end
    $display("test_boundary: %0d high samples", LONG - 1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] e, o;
    int n_short;
    n_short = 0;
    for (int i = 0; i < 62; i++) begin
      apply((i == 30 || i == 61) ? 1'b0 : 1'b1, e, o);
      n_short += o[3];
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL back_to_back sample=%0d got=%b want=%b", i, o, e);
      end
    end
    vectors++;
    if (n_short !== 2) begin
      miscompares++;
      $display("FAIL back_to_back_count got=%0d want=2", n_short);
    end
    $display("test_back_to_back: two 30-sample presses");
  endtask

  task automatic test_random();
    logic [3:0] e, o;
    int len, gap;
    for (int p = 0; p < 14; p++) begin
      len = $urandom_range(25, 175);
      gap = $urandom_range(1, 4);
      for (int i = 0; i < len + gap; i++) begin
        apply((i < len) ? 1'b1 : 1'b0, e, o);
        vectors++;
        if (o !== e || $countones(o[3:1]) > 1) begin
          miscompares++;
          $display("FAIL random press=%0d sample=%0d got=%b want=%b", p, i, o, e);
        end
      end
      $display("test_random: press %0d len=%0d gap=%0d", p, len, gap);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] e, o;
    int n_pulse;
    n_pulse = 0;
    for (int i = 1; i <= 110; i++) begin
      apply(1'b1, e, o);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL mid_reset_hold sample=%0d got=%b want=%b", i, o, e);
      end
    end
    #3;
    reset_n = 1'b0;
    #1;
    run = 0;
    vectors++;
    if (observe() !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset_async got=%b want=0000", observe());
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      vectors++;
      if (observe() !== 4'b0000) begin
        miscompares++;
        $display("FAIL mid_reset_held cycle=%0d got=%b want=0000", i, observe());
      end
    end
    bus_if.btn = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, e, o);
      n_pulse += $countones(o);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL mid_reset_after sample=%0d got=%b want=%b", i, o, e);
      end
    end
    vectors++;
    if (n_pulse !== 0) begin
      miscompares++;
      $display("FAIL mid_reset_pulses got=%0d want=0", n_pulse);
    end
    $display("test_mid_reset: reset asserted at hold sample 110");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    run         = 0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    auto_rep = 1'b1;
`else
    auto_rep = 1'b0;
`endif
    reset_n    = 1'b0;
    bus_if.btn = 1'b1;
    test_reset();
    test_short_press();
    test_long_press();
    test_auto_repeat();
    test_boundary();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
